alu_decode_stage: RTL and testbench

Registered, handshaked successor to the single-cycle ALU decoder: decodes opcode/funct3/funct7/ALUOp into a widened ALU control word that separates SRA from SRL and SLTU from SLT, flags illegal encodings, and can optionally decode RV32M ops. It sits between the main decoder and the execute stage of the pipelined core. A 2-entry skid buffer decouples backpressure from the execute stage.

---
 rtl/alu_decode_stage_if.sv | 38 +++
 rtl/alu_decode_stage.sv | 185 ++++++++++++++++++
 tb/tb_alu_decode_stage.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_decode_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_decode_stage_if
// Description : Upstream request / downstream result bundle of the ALU
//               decode stage. The master drives requests; the slave decodes.
// Revision    : 1.0
// ============================================================================
interface alu_decode_stage_if #(
    parameter int CTRL_W    = 5,
    parameter int TAG_W     = 5,
    parameter int ILL_CNT_W = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic [6:0]           funct7;
    logic [1:0]           alu_op;
    logic [TAG_W-1:0]     in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [CTRL_W-1:0]    alu_ctrl;
    logic                 is_muldiv;
    logic                 illegal;
    logic [TAG_W-1:0]     out_tag;
    logic [ILL_CNT_W-1:0] ill_count;

    modport master (
        output in_valid, opcode, funct3, funct7, alu_op, in_tag, out_ready,
        input  in_ready, out_valid, alu_ctrl, is_muldiv, illegal, out_tag, ill_count
    );

    modport slave (
        input  in_valid, opcode, funct3, funct7, alu_op, in_tag, out_ready,
        output in_ready, out_valid, alu_ctrl, is_muldiv, illegal, out_tag, ill_count
    );
endinterface
`default_nettype wire

// File: rtl/alu_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_decode_stage
// Description : Registered ALU control decoder behind a 2-entry skid buffer,
//               with a saturating illegal-decode counter. Define
//               ALU_DEC_MEXT_EN to decode RV32M ops (OP with funct7=0000001).
// Revision    : 1.0
// ============================================================================
module alu_decode_stage #(
    parameter int CTRL_W    = 5,
    parameter int TAG_W     = 5,
    parameter int ILL_CNT_W = 8
) (
    input  wire logic         clk,
    input  wire logic         reset,
    alu_decode_stage_if.slave bus
);
    localparam int ENT_W = CTRL_W + 2 + TAG_W;

    localparam logic [4:0] c_ADD  = 5'b00000;
    localparam logic [4:0] c_SUB  = 5'b00001;
    localparam logic [4:0] c_AND  = 5'b00010;
    localparam logic [4:0] c_OR   = 5'b00011;
    localparam logic [4:0] c_SLL  = 5'b00100;
    localparam logic [4:0] c_SLT  = 5'b00101;
    localparam logic [4:0] c_SRL  = 5'b00110;
    localparam logic [4:0] c_XOR  = 5'b00111;
    localparam logic [4:0] c_SRA  = 5'b01000;
    localparam logic [4:0] c_SLTU = 5'b01001;

    localparam logic [6:0] c_F7_STD = 7'b0000000;
    localparam logic [6:0] c_F7_ALT = 7'b0100000;
    localparam logic [6:0] c_F7_MUL = 7'b0000001;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [ENT_W-1:0]     out_q, out_d;
    logic [ENT_W-1:0]     skid_q, skid_d;
    logic [ILL_CNT_W-1:0] cnt_q, cnt_d;

    logic [4:0]        w_base;
    logic [4:0]        w_ctrl5;
    logic              w_muldiv;
    logic              w_illegal;
    logic [CTRL_W-1:0] w_ctrl;
    logic [ENT_W-1:0]  w_dec;
    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_in_xfer;
    logic              w_out_xfer;
    logic              w_unused;

    always_comb begin
        w_base = c_ADD;
        case (bus.funct3)
            3'b000:  w_base = c_ADD;
            3'b001:  w_base = c_SLL;
            3'b010:  w_base = c_SLT;
            3'b011:  w_base = c_SLTU;
            3'b100:  w_base = c_XOR;
            3'b101:  w_base = c_SRL;
            3'b110:  w_base = c_OR;
            default: w_base = c_AND;
        endcase
    end

    always_comb begin
        w_ctrl5   = c_ADD;
        w_muldiv  = 1'b0;
        w_illegal = 1'b0;
        case (bus.alu_op)
            2'b00: w_ctrl5 = c_ADD;
            2'b01: w_ctrl5 = c_SUB;
            2'b10: begin
                if (bus.opcode[5]) begin
                    if (bus.funct7 == c_F7_STD) begin
                        w_ctrl5 = w_base;
                    end else if (bus.funct7 == c_F7_ALT && bus.funct3 == 3'b000) begin
                        w_ctrl5 = c_SUB;
                    end else if (bus.funct7 == c_F7_ALT && bus.funct3 == 3'b101) begin
                        w_ctrl5 = c_SRA;
`ifdef ALU_DEC_MEXT_EN
                    end else if (bus.funct7 == c_F7_MUL) begin
                        w_ctrl5  = {2'b10, bus.funct3};
                        w_muldiv = 1'b1;
`endif
                    end else begin
                        w_illegal = 1'b1;
                    end
                end else begin
                    // OP-IMM: funct7 only matters for the shift encodings
                    if (bus.funct3 == 3'b001) begin
                        w_ctrl5   = c_SLL;
                        w_illegal = (bus.funct7 != c_F7_STD);
                    end else if (bus.funct3 == 3'b101) begin
                        if (bus.funct7 == c_F7_STD)      w_ctrl5 = c_SRL;
                        else if (bus.funct7 == c_F7_ALT) w_ctrl5 = c_SRA;
                        else                             w_illegal = 1'b1;
                    end else begin
                        w_ctrl5 = w_base;
                    end
                end
            end
            default: w_illegal = 1'b1;
        endcase
        if (w_illegal) begin
            w_ctrl5  = c_ADD;
            w_muldiv = 1'b0;
        end
    end

    assign w_ctrl = CTRL_W'(w_ctrl5);
    assign w_dec  = {w_ctrl, w_muldiv, w_illegal, bus.in_tag};

    // in_ready depends only on registered state, never on out_ready
    assign w_in_ready  = (state_q != S_FULL);
    assign w_out_valid = (state_q != S_EMPTY);
    assign w_in_xfer   = bus.in_valid & w_in_ready;
    assign w_out_xfer  = w_out_valid & bus.out_ready;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_EMPTY: begin
                if (w_in_xfer) begin
                    out_d   = w_dec;
                    state_d = S_ONE;
                end
            end
            S_ONE: begin
                if (w_in_xfer && w_out_xfer) begin
                    out_d = w_dec;
                end else if (w_in_xfer) begin
                    skid_d  = w_dec;
                    state_d = S_FULL;
                end else if (w_out_xfer) begin
                    state_d = S_EMPTY;
                end
            end
            S_FULL: begin
                if (w_out_xfer) begin
                    out_d   = skid_q;
                    state_d = S_ONE;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        if (w_out_xfer && out_q[TAG_W] && !(&cnt_q)) begin
            cnt_d = cnt_q + ILL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.alu_ctrl  = out_q[ENT_W-1 -: CTRL_W];
    assign bus.is_muldiv = out_q[TAG_W+1];
    assign bus.illegal   = out_q[TAG_W];
    assign bus.out_tag   = out_q[TAG_W-1:0];
    assign bus.ill_count = cnt_q;

    assign w_unused = ^{bus.opcode[6], bus.opcode[4:0]};
endmodule
`default_nettype wire

// File: tb/tb_alu_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_decode_stage
// Description : Self-checking bench: queue-based reference model plus directed
//               literal cases and randomized traffic with random resets.
// Revision    : 1.0
// ============================================================================
module tb_alu_decode_stage;
    localparam int CTRL_W    = 5;
    localparam int TAG_W     = 5;
    localparam int ILL_CNT_W = 8;
    localparam int CNT_MAX   = 255;

    typedef struct {
        logic [4:0] ctrl;
        logic       md;
        logic       ill;
        logic [4:0] tag;
    } ent_t;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   chk_on   = 1'b0;
    ent_t mq[$];
    int   m_cnt;
    int   base_code[8] = '{0, 4, 5, 9, 7, 6, 3, 2};

    alu_decode_stage_if #(.CTRL_W(CTRL_W), .TAG_W(TAG_W), .ILL_CNT_W(ILL_CNT_W)) bus ();

    alu_decode_stage #(.CTRL_W(CTRL_W), .TAG_W(TAG_W), .ILL_CNT_W(ILL_CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic ent_t model(input logic [1:0] aop, input logic [6:0] opc,
                                   input logic [2:0] f3, input logic [6:0] f7,
                                   input logic [4:0] tag);
        ent_t e;
        bit std, alt, mx;
        e.ctrl = 5'd0; e.md = 1'b0; e.ill = 1'b0; e.tag = tag;
        std = (f7 == 7'h00); alt = (f7 == 7'h20); mx = (f7 == 7'h01);
        if (aop == 2'b01) e.ctrl = 5'd1;
        else if (aop == 2'b11) e.ill = 1'b1;
        else if (aop == 2'b10) begin
            if (opc[5]) begin
                if (std) e.ctrl = 5'(base_code[f3]);
                else if (alt && f3 == 3'd0) e.ctrl = 5'd1;
                else if (alt && f3 == 3'd5) e.ctrl = 5'd8;
`ifdef ALU_DEC_MEXT_EN
                else if (mx) begin e.ctrl = 5'(16 + int'(f3)); e.md = 1'b1; end
`endif
                else e.ill = 1'b1;
            end else begin
                if (f3 == 3'd1 && !std) e.ill = 1'b1;
                else if (f3 == 3'd5) begin
                    if (std) e.ctrl = 5'd6;
                    else if (alt) e.ctrl = 5'd8;
                    else e.ill = 1'b1;
                end else e.ctrl = 5'(base_code[f3]);
            end
        end
        if (mx && !e.md) e.md = 1'b0;
        if (e.ill) begin e.ctrl = 5'd0; e.md = 1'b0; end
        return e;
    endfunction

    // Advance one clock, updating the model with the transfers seen before the edge.
    task automatic step();
        bit   ix, ox, rs;
        ent_t e;
        ix = bus.in_valid && (mq.size() < 2);
        ox = bus.out_ready && (mq.size() > 0);
        rs = reset;
        e  = model(bus.alu_op, bus.opcode, bus.funct3, bus.funct7, bus.in_tag);
        @(posedge clk);
        #1;
        if (rs) begin
            mq.delete();
            m_cnt = 0;
        end else begin
            if (ox) begin
                if (mq[0].ill && m_cnt < CNT_MAX) m_cnt++;
                void'(mq.pop_front());
            end
            if (ix) mq.push_back(e);
        end
    endtask

    task automatic send(input logic [1:0] aop, input logic [6:0] opc, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [4:0] tag);
        bus.in_valid = 1'b1;
        bus.alu_op   = aop;
        bus.opcode   = opc;
        bus.funct3   = f3;
        bus.funct7   = f7;
        bus.in_tag   = tag;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("in_ready", {31'd0, bus.in_ready}, {31'd0, mq.size() < 2});
            check("out_valid", {31'd0, bus.out_valid}, {31'd0, mq.size() > 0});
            check("ill_count", 32'(bus.ill_count), 32'(m_cnt));
            if (mq.size() > 0) begin
                check("alu_ctrl", 32'(bus.alu_ctrl), 32'(mq[0].ctrl));
                check("is_muldiv", {31'd0, bus.is_muldiv}, {31'd0, mq[0].md});
                check("illegal", {31'd0, bus.illegal}, {31'd0, mq[0].ill});
                check("out_tag", 32'(bus.out_tag), 32'(mq[0].tag));
            end
        end
    end

    initial begin
        logic [6:0] f7r;
        reset = 1'b1;
        bus.out_ready = 1'b0;
        send(2'b00, 7'd0, 3'd0, 7'd0, 5'd0);
        idle();
        step();
        chk_on = 1'b1;
        step();
        reset = 1'b0;
        step();
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_alu_ctrl", 32'(bus.alu_ctrl), 32'd0);
        check("rst_is_muldiv", {31'd0, bus.is_muldiv}, 32'd0);
        check("rst_illegal", {31'd0, bus.illegal}, 32'd0);
        check("rst_out_tag", 32'(bus.out_tag), 32'd0);
        check("rst_ill_count", 32'(bus.ill_count), 32'd0);

        send(2'b10, 7'b0110011, 3'b101, 7'b0100000, 5'd5);
        step();
        idle();
        check("sra_valid", {31'd0, bus.out_valid}, 32'd1);
        check("sra_ctrl", 32'(bus.alu_ctrl), 32'h08);
        check("sra_tag", 32'(bus.out_tag), 32'd5);
        bus.out_ready = 1'b1;
        step();

        // Backpressure: third request must wait while both entries are held
        bus.out_ready = 1'b0;
        send(2'b00, 7'b0000011, 3'b000, 7'd0, 5'd1);
        step();
        check("bp_ready1", {31'd0, bus.in_ready}, 32'd1);
        send(2'b10, 7'b0110011, 3'b011, 7'd0, 5'd2);
        step();
        check("bp_ready2", {31'd0, bus.in_ready}, 32'd0);
        check("bp_first", 32'(bus.alu_ctrl), 32'h00);
        send(2'b10, 7'b0110011, 3'b100, 7'd0, 5'd3);
        step();
        check("bp_hold_tag", 32'(bus.out_tag), 32'd1);
        bus.out_ready = 1'b1;
        step();
        check("bp_second", 32'(bus.alu_ctrl), 32'h09);
        check("bp_second_tag", 32'(bus.out_tag), 32'd2);
        step();
        idle();
        check("bp_third", 32'(bus.alu_ctrl), 32'h07);
        check("bp_third_tag", 32'(bus.out_tag), 32'd3);
        step();
        check("bp_drained", {31'd0, bus.out_valid}, 32'd0);

        reset = 1'b1;
        step();
        reset = 1'b0;
        send(2'b11, 7'b0110011, 3'b010, 7'd0, 5'd7);
        step();
        check("ill_aop11", {31'd0, bus.illegal}, 32'd1);
        check("ill_aop11_ctrl", 32'(bus.alu_ctrl), 32'd0);
        send(2'b10, 7'b0110011, 3'b111, 7'b0100000, 5'd8);
        step();
        idle();
        check("ill_alt_and", {31'd0, bus.illegal}, 32'd1);
        check("ill_alt_ctrl", 32'(bus.alu_ctrl), 32'd0);
        step();
        check("ill_count2", 32'(bus.ill_count), 32'd2);
        send(2'b11, 7'd0, 3'd0, 7'd0, 5'd9);
        repeat (300) step();
        idle();
        repeat (2) step();
        check("ill_sat", 32'(bus.ill_count), 32'd255);

        send(2'b10, 7'b0110011, 3'b100, 7'b0000001, 5'd4);
        step();
        idle();
`ifdef ALU_DEC_MEXT_EN
        check("mext_ctrl", 32'(bus.alu_ctrl), 32'h14);
        check("mext_md", {31'd0, bus.is_muldiv}, 32'd1);
        check("mext_ill", {31'd0, bus.illegal}, 32'd0);
`else
        check("mext_ctrl", 32'(bus.alu_ctrl), 32'h00);
        check("mext_md", {31'd0, bus.is_muldiv}, 32'd0);
        check("mext_ill", {31'd0, bus.illegal}, 32'd1);
`endif
        step();

        send(2'b10, 7'b0010011, 3'b001, 7'b0000000, 5'd10);
        step();
        check("imm_sll", 32'(bus.alu_ctrl), 32'h04);
        check("imm_sll_ill", {31'd0, bus.illegal}, 32'd0);
        send(2'b10, 7'b0010011, 3'b001, 7'b0100000, 5'd11);
        step();
        check("imm_sll_bad", {31'd0, bus.illegal}, 32'd1);
        send(2'b10, 7'b0010011, 3'b000, 7'b1111111, 5'd12);
        step();
        idle();
        check("imm_add", 32'(bus.alu_ctrl), 32'h00);
        check("imm_add_ill", {31'd0, bus.illegal}, 32'd0);
        step();

        // Reset while both entries are occupied: nothing may ever emerge
        bus.out_ready = 1'b0;
        send(2'b00, 7'd0, 3'd0, 7'd0, 5'd13);
        step();
        send(2'b01, 7'd0, 3'd0, 7'd0, 5'd14);
        step();
        idle();
        check("full_ready", {31'd0, bus.in_ready}, 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rstfull_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rstfull_ready", {31'd0, bus.in_ready}, 32'd1);
        bus.out_ready = 1'b1;
        repeat (3) step();
        check("rstfull_none", {31'd0, bus.out_valid}, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0:       f7r = 7'h00;
                1:       f7r = 7'h20;
                2:       f7r = 7'h01;
                default: f7r = 7'($urandom);
            endcase
            send(2'($urandom), 7'($urandom), 3'($urandom), f7r, 5'($urandom));
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            reset         = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 1'b0;
        idle();
        bus.out_ready = 1'b1;
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
